sdio_resp_tx: RTL and testbench
===============================

SDIO_RESP_TX -- requirements
Module: sdio_resp_tx

Interface
REQ-001 SHALL have parameter: NCR_CYCLES, 2, idle sd_clk cycles between response acceptance and the start bit; legal range 0..63.
REQ-002 SHALL have port: sd_clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: resp_valid  in  1  response request.
REQ-005 SHALL have port: resp_ready  out  1  block can accept a request.
REQ-006 SHALL have port: resp_index  in  6  command-index field of the response.
REQ-007 SHALL have port: resp_arg  in  32  argument/status field.
REQ-008 SHALL have port: resp_no_crc  in  1  send seven 1s in the CRC field (R3 style).
REQ-009 SHALL have port: resp_abort  in  1  synchronous abort of the frame in progress.
REQ-010 SHALL have port: sd_cmd_out  out  1  serial CMD line drive value.
REQ-011 SHALL have port: sd_cmd_dir  out  1  1 = block drives CMD, 0 = released.
REQ-012 SHALL have port: resp_busy  out  1  high in every state except IDLE.
REQ-013 SHALL have port: resp_done  out  1  one-cycle pulse marking end-bit cycle.

Function
REQ-014 SHALL implement states IDLE, NCR_WAIT, SHIFT, CRC, END_BIT.
REQ-015 SHALL assert resp_ready iff state is IDLE and resp_abort is 0.
REQ-016 SHALL accept a request on an edge with resp_valid=1 and resp_ready=1, latching index, arg and no_crc into a 40-bit frame register and a flag.
REQ-017 SHALL build the 40-bit frame MSB-first as start 0, transmission 0, resp_index[5:0], resp_arg[31:0].
REQ-018 SHALL go from IDLE to NCR_WAIT on acceptance when NCR_CYCLES>0, otherwise directly to SHIFT.
REQ-019 SHALL hold NCR_WAIT for exactly NCR_CYCLES cycles with sd_cmd_dir=0 and sd_cmd_out=1.
REQ-020 SHALL hold SHIFT for 40 cycles, presenting one frame bit per cycle MSB-first with sd_cmd_dir=1.
REQ-021 SHALL feed each SHIFT bit into CRC7 (polynomial x^7+x^3+1, initial value 0).
REQ-022 SHALL hold CRC for 7 cycles, sending CRC7 MSB-first, or 7'b1111111 when the latched no_crc flag is 1.
REQ-023 SHALL hold END_BIT for 1 cycle with sd_cmd_out=1, sd_cmd_dir=1 and resp_done=1, then return to IDLE.
REQ-024 SHALL make the start bit visible NCR_CYCLES+1 cycles after the accept edge, with the frame occupying exactly 48 consecutive driven cycles.
REQ-025 SHALL register sd_cmd_out and sd_cmd_dir, with no combinational path from any input to either.
REQ-026 SHALL drive sd_cmd_out=1 and sd_cmd_dir=0 in IDLE.
REQ-027 SHALL ignore resp_valid while resp_busy=1; the request neither queues nor corrupts the frame.
REQ-028 SHALL make resp_abort in any non-IDLE state return the block to IDLE on the next edge, release the line, suppress resp_done and clear CRC state.
REQ-029 SHALL give resp_abort priority over acceptance when it coincides with resp_valid in IDLE; nothing is accepted.
REQ-030 SHALL accept a new request in the first IDLE cycle after END_BIT, with no idle gap beyond NCR_CYCLES.

Reset
REQ-031 SHALL, while rst_n=0, force state IDLE, sd_cmd_out=1, sd_cmd_dir=0, resp_ready=0, resp_busy=0, resp_done=0, counters and CRC to 0, independent of sd_clk.
REQ-032 SHALL, on reset mid-frame, release the CMD line immediately and never emit a partial resp_done.
REQ-033 SHALL present resp_ready=1 at the first sd_clk edge after rst_n deasserts.

Structure
REQ-034 SHALL take the state enum, CRC7 polynomial 7'h09, frame length 48 and field widths from shared package sdio_pkg.
REQ-035 SHALL place the serial CRC7 in sub-module sdio_crc7 (sd_clk, rst_n, clear, enable, data bit, 7-bit crc out), reusable by the command receiver.

Verification
REQ-036 SHALL cover: index 0x11, arg 0x00000900, no_crc=0, NCR_CYCLES=2 -> line stays released 2 cycles, then 48 driven bits 0x110000090067, CRC field 0x33, resp_done in bit-48 cycle.
REQ-037 SHALL cover: index 0x3F, arg 0x00FF8000, no_crc=1 -> frame 0x3F00FF8000FF, CRC field 7'b1111111.
REQ-038 SHALL cover: resp_abort on cycle 10 of SHIFT -> sd_cmd_dir=0, sd_cmd_out=1 next cycle, no resp_done, resp_ready=1 in the following cycle.
REQ-039 SHALL cover: a second resp_valid held throughout frame 1 -> accepted only in the IDLE cycle after resp_done, with frame 2 start bit NCR_CYCLES+1 cycles later.
REQ-040 SHALL cover: rst_n low during CRC state -> outputs at reset values with no clock edge, and a clean frame after release.
REQ-041 SHALL cover: sdio_crc7 standalone on 40 bits 0x4000000000 -> crc 0x4A.

Source files
------------

// File: rtl/sdio_pkg.sv
// Shared SDIO constants: field widths, frame lengths, FSM encodings and the
// CRC7 step used by both the response transmitter and the command receiver.
package sdio_pkg;

    localparam int IDX_W     = 6;
    localparam int ARG_W     = 32;
    localparam int CRC_W     = 7;
    localparam int SHIFT_LEN = 40;
    localparam int FRAME_LEN = 48;

    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_NCR_WAIT = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_CRC      = 3'd3;
    localparam logic [2:0] ST_END_BIT  = 3'd4;

    // Start bit 0, transmission bit 0 (card to host), index, argument.
    function automatic logic [SHIFT_LEN-1:0] build_frame(
        input logic [IDX_W-1:0] idx,
        input logic [ARG_W-1:0] arg
    );
        return {2'b00, idx, arg};
    endfunction

    function automatic logic [CRC_W-1:0] crc7_step(
        input logic [CRC_W-1:0] crc,
        input logic             din
    );
        logic fb;
        fb = din ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled sd_clk edge, MSB-first data.
module sdio_crc7
    import sdio_pkg::*;
(
    input  logic             sd_clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    // Clear wins so a restart never mixes in bits from an aborted frame.
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = crc7_step(crc_q, din);
        end
    end

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sdio_resp_tx.sv
// SDIO response transmitter: serialises a 48-bit response frame onto CMD after
// an NCR gap. The line registers are loaded from the next state, so the driven
// bit always matches the state the FSM is in during that cycle.
module sdio_resp_tx
    import sdio_pkg::*;
#(
    parameter int NCR_CYCLES = 2
) (
    input  logic             sd_clk,
    input  logic             rst_n,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  logic [IDX_W-1:0] resp_index,
    input  logic [ARG_W-1:0] resp_arg,
    input  logic             resp_no_crc,
    input  logic             resp_abort,
    output logic             sd_cmd_out,
    output logic             sd_cmd_dir,
    output logic             resp_busy,
    output logic             resp_done,
    output logic [2:0]       dbg_state
);

    localparam logic [5:0] NCR_LAST   = 6'(NCR_CYCLES - 1);
    localparam logic [5:0] SHIFT_LAST = 6'(SHIFT_LEN - 1);
    localparam logic [5:0] CRC_LAST   = 6'(CRC_W - 1);
    localparam logic [2:0] CRC_TOP    = 3'(CRC_W - 1);

    logic [2:0]           state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [SHIFT_LEN-1:0] frame_q, frame_d;
    logic                 no_crc_q, no_crc_d;
    logic                 cmd_out_q, cmd_out_d;
    logic                 cmd_dir_q, cmd_dir_d;
    logic                 crc_clr, crc_en, crc_din;
    logic [CRC_W-1:0]     crc;
    logic [5:0]           bit_idx;
    logic                 accept;

    assign resp_ready = rst_n && (state_q == ST_IDLE) && !resp_abort;
    assign accept     = resp_valid && resp_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        no_crc_d  = no_crc_q;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        crc_din   = 1'b0;
        cmd_out_d = 1'b1;
        cmd_dir_d = 1'b0;
        bit_idx   = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    frame_d  = build_frame(resp_index, resp_arg);
                    no_crc_d = resp_no_crc;
                    cnt_d    = '0;
                    state_d  = (NCR_CYCLES > 0) ? ST_NCR_WAIT : ST_SHIFT;
                end
            end
            ST_NCR_WAIT: begin
                if (cnt_q == NCR_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    state_d = ST_CRC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_CRC: begin
                if (cnt_q == CRC_LAST) begin
                    state_d = ST_END_BIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_END_BIT: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (resp_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end

        // Every return to IDLE leaves the CRC at zero for the next frame.
        if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
            crc_clr = 1'b1;
        end

        // The CRC absorbs each frame bit on the same edge that drives it, so
        // it is complete by the first CRC-state cycle.
        case (state_d)
            ST_SHIFT: begin
                bit_idx   = SHIFT_LAST - cnt_d;
                cmd_out_d = frame_d[bit_idx];
                cmd_dir_d = 1'b1;
                crc_en    = 1'b1;
                crc_din   = frame_d[bit_idx];
            end
            ST_CRC: begin
                cmd_out_d = no_crc_q | crc[CRC_TOP - cnt_d[2:0]];
                cmd_dir_d = 1'b1;
            end
            ST_END_BIT: begin
                cmd_out_d = 1'b1;
                cmd_dir_d = 1'b1;
            end
            default: begin
                cmd_out_d = 1'b1;
                cmd_dir_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            frame_q   <= '0;
            no_crc_q  <= 1'b0;
            cmd_out_q <= 1'b1;
            cmd_dir_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            no_crc_q  <= no_crc_d;
            cmd_out_q <= cmd_out_d;
            cmd_dir_q <= cmd_dir_d;
        end
    end

    sdio_crc7 u_crc7 (
        .sd_clk (sd_clk),
        .rst_n  (rst_n),
        .clear  (crc_clr),
        .enable (crc_en),
        .din    (crc_din),
        .crc    (crc)
    );

    assign sd_cmd_out = cmd_out_q;
    assign sd_cmd_dir = cmd_dir_q;
    assign resp_busy  = (state_q != ST_IDLE);
    assign resp_done  = (state_q == ST_END_BIT) && !resp_abort;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sdio_resp_tx.sv
// Directed bench for sdio_resp_tx and the standalone sdio_crc7.
module tb_sdio_resp_tx;

    localparam int NCR = 2;

    logic        sd_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [5:0]  resp_index = '0;
    logic [31:0] resp_arg = '0;
    logic        resp_no_crc = 1'b0;
    logic        resp_abort = 1'b0;
    logic        sd_cmd_out;
    logic        sd_cmd_dir;
    logic        resp_busy;
    logic        resp_done;
    logic [2:0]  dbg_state;

    logic        c_clear = 1'b0;
    logic        c_en = 1'b0;
    logic        c_din = 1'b0;
    logic [6:0]  c_crc;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 sd_clk = ~sd_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    sdio_resp_tx #(.NCR_CYCLES(NCR)) dut (
        .sd_clk      (sd_clk),
        .rst_n       (rst_n),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_index  (resp_index),
        .resp_arg    (resp_arg),
        .resp_no_crc (resp_no_crc),
        .resp_abort  (resp_abort),
        .sd_cmd_out  (sd_cmd_out),
        .sd_cmd_dir  (sd_cmd_dir),
        .resp_busy   (resp_busy),
        .resp_done   (resp_done),
        .dbg_state   (dbg_state)
    );

    sdio_crc7 u_crc (
        .sd_clk (sd_clk),
        .rst_n  (rst_n),
        .clear  (c_clear),
        .enable (c_en),
        .din    (c_din),
        .crc    (c_crc)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    // Accepts the request currently on the inputs and captures the whole frame.
    task automatic capture(input string tag, input logic [47:0] exp, input logic [6:0] exp_crc,
                           input logic [5:0] n_idx, input logic [31:0] n_arg,
                           input logic n_nocrc, input logic n_valid);
        logic [47:0] got;
        int bad_ncr;
        int bad_drv;
        int done_cnt;
        logic done_last;
        check_eq({tag, "_ready"}, 64'(resp_ready), 64'd1);
        tick();
        resp_index  = n_idx;
        resp_arg    = n_arg;
        resp_no_crc = n_nocrc;
        resp_valid  = n_valid;
        bad_ncr = 0;
        for (int i = 0; i < NCR; i++) begin
            if (sd_cmd_dir !== 1'b0 || sd_cmd_out !== 1'b1 || resp_busy !== 1'b1) bad_ncr++;
            tick();
        end
        got = '0;
        bad_drv = 0;
        done_cnt = 0;
        done_last = 1'b0;
        for (int b = 0; b < 48; b++) begin
            got = {got[46:0], sd_cmd_out};
            if (sd_cmd_dir !== 1'b1 || resp_busy !== 1'b1 || resp_ready !== 1'b0) bad_drv++;
            if (resp_done === 1'b1) begin
                done_cnt++;
                if (b == 47) done_last = 1'b1;
            end
            if (b < 47) tick();
        end
        check_eq({tag, "_ncr_released"}, 64'(bad_ncr), 64'd0);
        check_eq({tag, "_driven"}, 64'(bad_drv), 64'd0);
        check_eq({tag, "_frame"}, 64'(got), 64'(exp));
        check_eq({tag, "_crc_field"}, 64'(got[7:1]), 64'(exp_crc));
        check_eq({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check_eq({tag, "_done_bit48"}, 64'(done_last), 64'd1);
        tick();
        check_eq({tag, "_idle_after"}, 64'({sd_cmd_dir, sd_cmd_out, resp_busy, resp_ready, resp_done}),
                 64'(5'b01010));
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        logic [39:0] vec;

        // Reset state, no clock edge dependence.
        #12;
        check_eq("reset_outputs", 64'({sd_cmd_out, sd_cmd_dir, resp_ready, resp_busy, resp_done}),
                 64'(5'b10000));
        check_eq("reset_state", 64'(dbg_state), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("ready_after_reset", 64'(resp_ready), 64'd1);
        tick();

        // Basic R1-style frame.
        resp_index = 6'h11; resp_arg = 32'h0000_0900; resp_no_crc = 1'b0; resp_valid = 1'b1;
        capture("f1", 48'h1100_0009_0067, 7'h33, 6'h00, 32'h0, 1'b0, 1'b0);

        // No-CRC frame.
        resp_index = 6'h3F; resp_arg = 32'h00FF_8000; resp_no_crc = 1'b1; resp_valid = 1'b1;
        capture("f2", 48'h3F00_FF80_00FF, 7'h7F, 6'h00, 32'h0, 1'b0, 1'b0);

        // Abort in IDLE beats a simultaneous request.
        resp_index = 6'h11; resp_arg = 32'h0000_0900; resp_no_crc = 1'b0;
        resp_valid = 1'b1; resp_abort = 1'b1;
        #1;
        check_eq("abort_idle_ready", 64'(resp_ready), 64'd0);
        tick();
        check_eq("abort_idle_state", 64'({resp_busy, dbg_state}), 64'd0);
        resp_abort = 1'b0;
        resp_valid = 1'b0;
        tick();

        // Abort on cycle 10 of SHIFT.
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        for (int i = 0; i < NCR; i++) tick();
        for (int i = 0; i < 9; i++) tick();
        check_eq("abort_pre_state", 64'(dbg_state), 64'd2);
        resp_abort = 1'b1;
        tick();
        check_eq("abort_line", 64'({sd_cmd_dir, sd_cmd_out, resp_done, resp_busy}), 64'(4'b0100));
        resp_abort = 1'b0;
        #1;
        check_eq("abort_ready", 64'(resp_ready), 64'd1);
        begin
            int done_seen;
            done_seen = 0;
            for (int i = 0; i < 60; i++) begin
                if (resp_done === 1'b1 || sd_cmd_dir !== 1'b0) done_seen++;
                tick();
            end
            check_eq("abort_no_done", 64'(done_seen), 64'd0);
        end
        resp_index = 6'h11; resp_arg = 32'h0000_0900; resp_no_crc = 1'b0; resp_valid = 1'b1;
        capture("after_abort", 48'h1100_0009_0067, 7'h33, 6'h00, 32'h0, 1'b0, 1'b0);

        // Request held through a frame, inputs changed mid-frame.
        resp_index = 6'h11; resp_arg = 32'h0000_0900; resp_no_crc = 1'b0; resp_valid = 1'b1;
        capture("held1", 48'h1100_0009_0067, 7'h33, 6'h3F, 32'h00FF_8000, 1'b1, 1'b1);
        capture("held2", 48'h3F00_FF80_00FF, 7'h7F, 6'h00, 32'h0, 1'b0, 1'b0);

        // Reset asserted during the CRC state.
        resp_index = 6'h11; resp_arg = 32'h0000_0900; resp_no_crc = 1'b0; resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        for (int i = 0; i < NCR + 42; i++) tick();
        check_eq("rst_pre_state", 64'(dbg_state), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outputs", 64'({sd_cmd_out, sd_cmd_dir, resp_ready, resp_busy, resp_done}),
                 64'(5'b10000));
        check_eq("rst_mid_state", 64'(dbg_state), 64'd0);
        tick();
        check_eq("rst_hold_done", 64'(resp_done), 64'd0);
        rst_n = 1'b1;
        tick();
        resp_index = 6'h11; resp_arg = 32'h0000_0900; resp_no_crc = 1'b0; resp_valid = 1'b1;
        capture("after_rst", 48'h1100_0009_0067, 7'h33, 6'h00, 32'h0, 1'b0, 1'b0);

        // Standalone CRC7.
        vec = 40'h40_0000_0000;
        c_clear = 1'b1;
        tick();
        c_clear = 1'b0;
        check_eq("crc_clear", 64'(c_crc), 64'd0);
        c_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            c_din = vec[39 - i];
            tick();
        end
        c_en = 1'b0;
        check_eq("crc_cmd0", 64'(c_crc), 64'h4A);
        vec = 40'h11_0000_0900;
        c_clear = 1'b1;
        tick();
        c_clear = 1'b0;
        c_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            c_din = vec[39 - i];
            tick();
        end
        c_en = 1'b0;
        check_eq("crc_r1", 64'(c_crc), 64'h33);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
